// File: rtl/line_interleave_scheduler.sv
// Two-input, one-output token scheduler: grants the single output to one
// input stream for LINE_LEN tokens, then to the other, alternating forever.
module line_interleave_scheduler #(
    parameter int DW       = 16,
    parameter int LINE_LEN = 512,
    parameter bit FIRST    = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] In1_DATA,
    input  logic          In1_SEND,
    input  logic [15:0]   In1_COUNT,
    output logic          In1_ACK,
    input  logic [DW-1:0] In2_DATA,
    input  logic          In2_SEND,
    input  logic [15:0]   In2_COUNT,
    output logic          In2_ACK,
    output logic [DW-1:0] Out1_DATA,
    output logic          Out1_SEND,
    output logic [15:0]   Out1_COUNT,
    input  logic          Out1_RDY,
    input  logic          Out1_ACK,
    output logic          sel
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    localparam logic [15:0] LAST_BEAT   = 16'(LINE_LEN - 1);
    localparam state_t      FIRST_GRANT = FIRST ? GRANT2 : GRANT1;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [1:0]  kick_reg, kick_next;
    logic        fire1, fire2;

    // Token counts are informational and downstream ACK carries no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{In1_COUNT, In2_COUNT, Out1_ACK};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= START;
            cnt_reg   <= 16'd0;
            kick_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            kick_reg  <= kick_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        kick_next  = kick_reg;
        fire1      = (state_reg == GRANT1) && In1_SEND && Out1_RDY;
        fire2      = (state_reg == GRANT2) && In2_SEND && Out1_RDY;
        sel        = FIRST;

        case (state_reg)
            START: begin
                // Two idle edges after reset before the first grant opens.
                kick_next = kick_reg + 2'd1;
                if (kick_reg == 2'd1) begin
                    state_next = FIRST_GRANT;
                end
            end
            GRANT1: begin
                sel = 1'b0;
                if (fire1) begin
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = 16'd0;
                        state_next = GRANT2;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            GRANT2: begin
                sel = 1'b1;
                if (fire2) begin
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = 16'd0;
                        state_next = GRANT1;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    assign In1_ACK    = fire1;
    assign In2_ACK    = fire2;
    assign Out1_SEND  = fire1 | fire2;
    assign Out1_DATA  = fire1 ? In1_DATA : (fire2 ? In2_DATA : '0);
    assign Out1_COUNT = 16'h0001;

endmodule
